// File: rtl/demux8_dispatch_if.sv
// Producer/consumer bus of the 1-to-8 dispatcher.
// DEMUX8_BCAST_EN adds the in_bcast request line.
interface demux8_dispatch_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_dest;
`ifdef DEMUX8_BCAST_EN
    logic             in_bcast;
`endif
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;

`ifdef DEMUX8_BCAST_EN
    modport master (output in_valid, in_data, in_dest, in_bcast, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_valid, in_data, in_dest, in_bcast, out_ready,
                    output in_ready, out_data, out_valid);
`else
    modport master (output in_valid, in_data, in_dest, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_valid, in_data, in_dest, out_ready,
                    output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/demux8_dispatch.sv
// Registered 1-to-8 dispatcher behind a 2-entry FIFO; outputs depend only on state.
// DEMUX8_BCAST_EN enables broadcast entries delivered to all eight channels.
module demux8_dispatch #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    demux8_dispatch_if.slave   bus,
    output logic [1:0]         occupancy
);
    typedef struct packed {
`ifdef DEMUX8_BCAST_EN
        logic             bcast;
`endif
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    entry_t     head;
    entry_t     wr_entry;
    logic       push;
    logic       pop;
    logic [7:0] fire;
`ifdef DEMUX8_BCAST_EN
    logic [7:0] done_mask;
`endif

    assign head         = mem[rd_ptr];
    assign bus.in_ready = (count != 2'd2);
    assign occupancy    = count;
    assign push         = bus.in_valid & bus.in_ready;
    assign fire         = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_entry      = '0;
        wr_entry.dest = bus.in_dest;
        wr_entry.data = bus.in_data;
`ifdef DEMUX8_BCAST_EN
        wr_entry.bcast = bus.in_bcast;
`endif
    end

    // Broadcast heads offer every channel not yet served and retire once all eight have taken it.
    always_comb begin
        bus.out_valid = 8'h00;
        bus.out_data  = '0;
        pop           = |fire;
        if (count != 2'd0) begin
            bus.out_valid = 8'b1 << head.dest;
            bus.out_data  = head.data;
`ifdef DEMUX8_BCAST_EN
            if (head.bcast) begin
                bus.out_valid = ~done_mask;
                pop           = ((done_mask | fire) == 8'hFF);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
`ifdef DEMUX8_BCAST_EN
            done_mask <= 8'h00;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
`ifdef DEMUX8_BCAST_EN
            done_mask <= pop ? 8'h00 : (done_mask | fire);
`endif
        end
    end
endmodule

// File: tb/tb_demux8_dispatch.sv
// Directed bench for demux8_dispatch; a queue model predicts every output each cycle.
module tb_demux8_dispatch;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] occupancy;
    logic       bc_in;

    demux8_dispatch_if #(.WIDTH(32)) bus ();
    demux8_dispatch #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus), .occupancy(occupancy));

`ifdef DEMUX8_BCAST_EN
    assign bus.in_bcast = bc_in;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit          bc;
        logic [2:0]  dest;
        logic [31:0] data;
    } item_t;

    item_t      q[$];
    logic [7:0] tb_done = 8'h00;
    bit         init = 1'b0;
    int         npass = 0;
    int         ntot = 0;
    int         npop = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Check outputs mid-cycle against the model, then advance model and DUT one edge.
    task automatic cycle();
        item_t      h;
        logic [7:0] exp_v;
        logic [7:0] f;
        bit         pop, push;
        h = '{bc: 1'b0, dest: 3'd0, data: 32'd0};
        exp_v = 8'h00;
        @(negedge clk);
        if (q.size() != 0) begin
            h = q[0];
            exp_v = h.bc ? ~tb_done : (8'b1 << h.dest);
        end
        if (init) begin
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            chk("out_data", 64'(bus.out_data), (q.size() != 0) ? 64'(h.data) : 64'd0);
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() != 2));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
        end
        f    = exp_v & bus.out_ready;
        pop  = h.bc ? ((tb_done | f) == 8'hFF) : (f != 8'h00);
        push = bus.in_valid && (q.size() < 2);
        @(posedge clk);
        if (rst) begin
            q.delete();
            tb_done = 8'h00;
            init = 1'b1;
        end else if (init) begin
            if (pop) begin
                void'(q.pop_front());
                npop++;
                tb_done = 8'h00;
            end else if (h.bc) begin
                tb_done = tb_done | f;
            end
            if (push)
                q.push_back('{bc: bc_in, dest: bus.in_dest, data: bus.in_data});
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] d, input logic [31:0] x, input bit b);
        bus.in_valid = v;
        bus.in_dest  = d;
        bus.in_data  = x;
        bc_in        = b;
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'hFF;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        cycle();
        chk(tag, 64'(occupancy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 3'd2, 32'hAAAA, 1'b0);
        bus.out_ready = 8'h00;
        cycle();
        cycle();
        chk("reset_out_valid", 64'(bus.out_valid), 64'h00);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_data", 64'(bus.out_data), 64'd0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        cycle();
        cycle();
        chk("idle_no_dispatch", 64'(bus.out_valid), 64'h00);

        // single item, retires on first visible edge
        bus.out_ready = 8'hFF;
        drive(1'b1, 3'd5, 32'hDEADBEEF, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        chk("single_valid", 64'(bus.out_valid), 64'h20);
        chk("single_data", 64'(bus.out_data), 64'hDEADBEEF);
        cycle();
        chk("single_retire", 64'(occupancy), 64'd0);

        // backpressure until full, third push refused
        bus.out_ready = 8'h00;
        drive(1'b1, 3'd1, 32'h11, 1'b0);
        cycle();
        drive(1'b1, 3'd6, 32'h66, 1'b0);
        cycle();
        drive(1'b1, 3'd3, 32'h33, 1'b0);
        cycle();
        cycle();
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        chk("full_valid", 64'(bus.out_valid), 64'h02);
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        bus.out_ready = 8'h02;
        cycle();
        bus.out_ready = 8'h00;
        chk("second_head", 64'(bus.out_valid), 64'h40);
        cycle();
        drain("full_drain");

        // head-of-line blocking
        bus.out_ready = 8'h00;
        drive(1'b1, 3'd3, 32'hC3, 1'b0);
        cycle();
        drive(1'b1, 3'd0, 32'hC0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        bus.out_ready = 8'hF7;
        repeat (5) cycle();
        chk("hol_valid", 64'(bus.out_valid), 64'h08);
        chk("hol_data", 64'(bus.out_data), 64'hC3);
        bus.out_ready = 8'h08;
        cycle();
        chk("hol_next", 64'(bus.out_valid), 64'h01);
        drain("hol_drain");

        // streaming: one item per cycle
        npop = 0;
        bus.out_ready = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'(i % 8), 32'(i), 1'b0);
            cycle();
        end
        drain("stream_drain");
        chk("stream_count", 64'(npop), 64'd16);

`ifdef DEMUX8_BCAST_EN
        bus.out_ready = 8'h00;
        drive(1'b1, 3'd5, 32'd7, 1'b1);
        cycle();
        drive(1'b1, 3'd2, 32'd8, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        chk("bcast_valid", 64'(bus.out_valid), 64'hFF);
        bus.out_ready = 8'h0F;
        cycle();
        chk("bcast_partial", 64'(bus.out_valid), 64'hF0);
        bus.out_ready = 8'hF0;
        cycle();
        bus.out_ready = 8'h00;
        chk("bcast_next", 64'(bus.out_valid), 64'h04);
        chk("bcast_next_data", 64'(bus.out_data), 64'd8);
        cycle();
        drain("bcast_drain");
`endif

        // reset mid-transfer drops held items
        bus.out_ready = 8'h00;
        drive(1'b1, 3'd4, 32'h44, 1'b0);
        cycle();
        cycle();
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midreset_occ", 64'(occupancy), 64'd0);
        chk("midreset_valid", 64'(bus.out_valid), 64'h00);
        cycle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
